// File: rtl/lemming_tracker_if.sv
// Walker-to-tracker bundle: walker outputs in, tracker status out.
// turn_cnt exists only when TURN_COUNT_EN is defined.
interface lemming_tracker_if #(
    parameter int X_W    = 8,
    parameter int FALL_W = 5
);
    logic              walk_left;
    logic              walk_right;
    logic              aaah;
    logic [1:0]        state;
    logic [X_W-1:0]    x_pos;
    logic [FALL_W-1:0] fall_cnt;
    logic              landed;
    logic              splat;
    logic              alive;
    logic              protocol_err;
`ifdef TURN_COUNT_EN
    logic [7:0]        turn_cnt;
`endif

    modport master (
        output walk_left, walk_right, aaah,
        input  state, x_pos, fall_cnt, landed, splat, alive, protocol_err
`ifdef TURN_COUNT_EN
        , input turn_cnt
`endif
    );

    modport slave (
        input  walk_left, walk_right, aaah,
        output state, x_pos, fall_cnt, landed, splat, alive, protocol_err
`ifdef TURN_COUNT_EN
        , output turn_cnt
`endif
    );
endinterface

// File: rtl/lemming_tracker.sv
// Lemming position/fall tracker with landing-vs-splat decision; TURN_COUNT_EN adds turn_cnt.
// Latency 1 cycle, all outputs registered; no backpressure, one walker sample per clk.
module lemming_tracker #(
    parameter int X_W          = 8,
    parameter int X_START      = 128,
    parameter int X_MIN        = 0,
    parameter int X_MAX        = 255,
    parameter int FALL_W       = 5,
    parameter int SPLAT_CYCLES = 20
) (
    input logic              clk,
    input logic              areset,
    lemming_tracker_if.slave trk
);
    typedef enum logic [1:0] {
        WALK_L = 2'b00,
        WALK_R = 2'b01,
        FALL   = 2'b10,
        DEAD   = 2'b11
    } state_t;

    localparam logic [X_W-1:0]    LP_X_START = X_W'(X_START);
    localparam logic [X_W-1:0]    LP_X_MIN   = X_W'(X_MIN);
    localparam logic [X_W-1:0]    LP_X_MAX   = X_W'(X_MAX);
    localparam logic [FALL_W-1:0] LP_FALL_MX = '1;
    localparam logic [FALL_W-1:0] LP_SPLAT   = FALL_W'(SPLAT_CYCLES);

    state_t            r_state,        w_state_nxt;
    logic [X_W-1:0]    r_x_pos,        w_x_pos_nxt;
    logic [FALL_W-1:0] r_fall_cnt,     w_fall_cnt_nxt;
    logic              r_landed,       w_landed_nxt;
    logic              r_splat,        w_splat_nxt;
    logic              r_alive,        w_alive_nxt;
    logic              r_protocol_err, w_protocol_err_nxt;

    logic w_l, w_r, w_f;
    assign w_l = trk.walk_left  & ~trk.walk_right & ~trk.aaah;
    assign w_r = trk.walk_right & ~trk.walk_left  & ~trk.aaah;
    assign w_f = trk.aaah       & ~trk.walk_left  & ~trk.walk_right;

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            r_state        <= WALK_L;
            r_x_pos        <= LP_X_START;
            r_fall_cnt     <= '0;
            r_landed       <= 1'b0;
            r_splat        <= 1'b0;
            r_alive        <= 1'b1;
            r_protocol_err <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_x_pos        <= w_x_pos_nxt;
            r_fall_cnt     <= w_fall_cnt_nxt;
            r_landed       <= w_landed_nxt;
            r_splat        <= w_splat_nxt;
            r_alive        <= w_alive_nxt;
            r_protocol_err <= w_protocol_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt        = r_state;
        w_x_pos_nxt        = r_x_pos;
        w_fall_cnt_nxt     = r_fall_cnt;
        w_landed_nxt       = 1'b0;
        w_splat_nxt        = r_splat;
        w_alive_nxt        = r_alive;
        w_protocol_err_nxt = r_protocol_err;
        case (r_state)
            WALK_L, WALK_R: begin
                if (w_l) begin
                    w_state_nxt = WALK_L;
                    if (r_x_pos > LP_X_MIN) w_x_pos_nxt = r_x_pos - 1'b1;
                end else if (w_r) begin
                    w_state_nxt = WALK_R;
                    if (r_x_pos < LP_X_MAX) w_x_pos_nxt = r_x_pos + 1'b1;
                end else if (w_f) begin
                    w_state_nxt    = FALL;
                    w_fall_cnt_nxt = FALL_W'(1);
                end else begin
                    w_protocol_err_nxt = 1'b1;
                end
            end
            FALL: begin
                if (w_f) begin
                    if (r_fall_cnt != LP_FALL_MX) w_fall_cnt_nxt = r_fall_cnt + 1'b1;
                end else if (w_l || w_r) begin
                    // Fatal landing freezes x_pos/fall_cnt so the display shows the final fall.
                    if (r_fall_cnt >= LP_SPLAT) begin
                        w_state_nxt = DEAD;
                        w_splat_nxt = 1'b1;
                        w_alive_nxt = 1'b0;
                    end else begin
                        w_state_nxt    = w_l ? WALK_L : WALK_R;
                        w_landed_nxt   = 1'b1;
                        w_fall_cnt_nxt = '0;
                    end
                end else begin
                    w_protocol_err_nxt = 1'b1;
                end
            end
            default: ;
        endcase
    end

`ifdef TURN_COUNT_EN
    logic [7:0] r_turn_cnt;
    logic       w_turn;
    // Only direct walk-to-walk reversals count; FALL breaks the chain.
    assign w_turn = ((r_state == WALK_L) && w_r) || ((r_state == WALK_R) && w_l);

    always_ff @(posedge clk or posedge areset) begin
        if (areset)                              r_turn_cnt <= '0;
        else if (w_turn && r_turn_cnt != 8'hFF)  r_turn_cnt <= r_turn_cnt + 8'd1;
    end

    assign trk.turn_cnt = r_turn_cnt;
`endif

    assign trk.state        = r_state;
    assign trk.x_pos        = r_x_pos;
    assign trk.fall_cnt     = r_fall_cnt;
    assign trk.landed       = r_landed;
    assign trk.splat        = r_splat;
    assign trk.alive        = r_alive;
    assign trk.protocol_err = r_protocol_err;
endmodule

// File: tb/tb_lemming_tracker.sv
// Directed-vector bench for lemming_tracker; inputs change and outputs are sampled on the falling edge.
module tb_lemming_tracker;
    logic clk    = 1'b0;
    logic areset = 1'b1;
    int   n_cmp  = 0;
    int   n_err  = 0;

    lemming_tracker_if #(.X_W(8), .FALL_W(5)) lif ();

    lemming_tracker dut (
        .clk    (clk),
        .areset (areset),
        .trk    (lif)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic l, input logic r, input logic a, input int n);
        for (int i = 0; i < n; i++) begin
            lif.walk_left  = l;
            lif.walk_right = r;
            lif.aaah       = a;
            @(negedge clk);
        end
    endtask

    task automatic do_reset();
        areset         = 1'b1;
        lif.walk_left  = 1'b0;
        lif.walk_right = 1'b0;
        lif.aaah       = 1'b0;
        @(negedge clk);
        areset = 1'b0;
    endtask

    initial begin
        lif.walk_left  = 1'b0;
        lif.walk_right = 1'b0;
        lif.aaah       = 1'b0;

        // Reset values
        do_reset();
        check_val("rst_state",  32'(lif.state), 0);
        check_val("rst_x",      32'(lif.x_pos), 128);
        check_val("rst_fall",   32'(lif.fall_cnt), 0);
        check_val("rst_landed", 32'(lif.landed), 0);
        check_val("rst_splat",  32'(lif.splat), 0);
        check_val("rst_alive",  32'(lif.alive), 1);
        check_val("rst_perr",   32'(lif.protocol_err), 0);

        // Walk left 5
        drive(1, 0, 0, 5);
        check_val("wl5_x",      32'(lif.x_pos), 123);
        check_val("wl5_state",  32'(lif.state), 0);
        check_val("wl5_landed", 32'(lif.landed), 0);

        // Walk right into the upper bound
        do_reset();
        drive(0, 1, 0, 130);
        check_val("wr130_x",     32'(lif.x_pos), 255);
        check_val("wr130_state", 32'(lif.state), 1);

        // Short fall and survivable landing
        drive(0, 0, 1, 5);
        check_val("f5_state",  32'(lif.state), 2);
        check_val("f5_fall",   32'(lif.fall_cnt), 5);
        check_val("f5_x",      32'(lif.x_pos), 255);
        check_val("f5_landed", 32'(lif.landed), 0);
        drive(0, 1, 0, 1);
        check_val("land_landed", 32'(lif.landed), 1);
        check_val("land_fall",   32'(lif.fall_cnt), 0);
        check_val("land_state",  32'(lif.state), 1);
        check_val("land_x",      32'(lif.x_pos), 255);
        drive(0, 1, 0, 1);
        check_val("land_pulse_end", 32'(lif.landed), 0);
        check_val("post_land_x",    32'(lif.x_pos), 255);

        // L,L,R,R,L then fall 3, land right
        do_reset();
        drive(1, 0, 0, 2);
        drive(0, 1, 0, 2);
        drive(1, 0, 0, 1);
        drive(0, 0, 1, 3);
        drive(0, 1, 0, 1);
        check_val("turn_seq_x",      32'(lif.x_pos), 127);
        check_val("turn_seq_state",  32'(lif.state), 1);
        check_val("turn_seq_landed", 32'(lif.landed), 1);
`ifdef TURN_COUNT_EN
        check_val("turn_cnt", 32'(lif.turn_cnt), 2);
`endif

        // Illegal combinations hold state and set sticky protocol_err
        drive(1, 1, 0, 1);
        check_val("ill_perr",  32'(lif.protocol_err), 1);
        check_val("ill_state", 32'(lif.state), 1);
        check_val("ill_x",     32'(lif.x_pos), 127);
        drive(0, 0, 0, 1);
        check_val("none_x",    32'(lif.x_pos), 127);
        drive(1, 0, 1, 1);
        check_val("la_state",  32'(lif.state), 1);
        drive(1, 0, 0, 1);
        check_val("resume_state", 32'(lif.state), 0);
        check_val("resume_x",     32'(lif.x_pos), 126);
        check_val("resume_perr",  32'(lif.protocol_err), 1);

        // Fall of exactly SPLAT_CYCLES kills
        do_reset();
        drive(0, 0, 1, 20);
        check_val("f20_fall", 32'(lif.fall_cnt), 20);
        drive(1, 0, 0, 1);
        check_val("splat_state",  32'(lif.state), 3);
        check_val("splat_splat",  32'(lif.splat), 1);
        check_val("splat_alive",  32'(lif.alive), 0);
        check_val("splat_landed", 32'(lif.landed), 0);
        check_val("splat_fall",   32'(lif.fall_cnt), 20);
        drive(0, 1, 0, 10);
        check_val("dead_x",     32'(lif.x_pos), 128);
        check_val("dead_state", 32'(lif.state), 3);
        drive(1, 1, 1, 1);
        check_val("dead_perr", 32'(lif.protocol_err), 0);
        do_reset();
        check_val("revive_x",     32'(lif.x_pos), 128);
        check_val("revive_alive", 32'(lif.alive), 1);
        check_val("revive_splat", 32'(lif.splat), 0);
        check_val("revive_state", 32'(lif.state), 0);
        check_val("revive_fall",  32'(lif.fall_cnt), 0);

        // One below threshold survives
        drive(0, 0, 1, 19);
        drive(1, 0, 0, 1);
        check_val("f19_landed", 32'(lif.landed), 1);
        check_val("f19_state",  32'(lif.state), 0);
        check_val("f19_splat",  32'(lif.splat), 0);

        // fall_cnt saturation, then fatal landing
        drive(0, 0, 1, 35);
        check_val("fsat_fall", 32'(lif.fall_cnt), 31);
        drive(0, 1, 0, 1);
        check_val("fsat_state", 32'(lif.state), 3);

        // Lower bound saturation
        do_reset();
        drive(1, 0, 0, 130);
        check_val("wl130_x",     32'(lif.x_pos), 0);
        check_val("wl130_state", 32'(lif.state), 0);

        // Asynchronous reset mid-fall
        drive(0, 0, 1, 3);
        check_val("pre_ar_fall", 32'(lif.fall_cnt), 3);
        areset = 1'b1;
        #1;
        check_val("ar_state",  32'(lif.state), 0);
        check_val("ar_fall",   32'(lif.fall_cnt), 0);
        check_val("ar_x",      32'(lif.x_pos), 128);
        check_val("ar_landed", 32'(lif.landed), 0);
        @(negedge clk);
        areset = 1'b0;
        check_val("ar_held_state", 32'(lif.state), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
